// File: rtl/div_unit.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle; Result and div_zero are held until the next accepted start.
module div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t           state;
  logic             sel_rem;   // op[1]: return remainder instead of quotient
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    count;

  // Operand magnitudes; |-2^(W-1)| wraps to 2^(W-1), which is correct when read as unsigned.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign a_neg = ~op[0] & A[WIDTH-1];
  assign b_neg = ~op[0] & B[WIDTH-1];
  assign a_abs = a_neg ? -A : A;
  assign b_abs = b_neg ? -B : B;

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    diff     = trial - {1'b0, divisor};
    fits     = (trial >= {1'b0, divisor});
    rem_next = trial[WIDTH-1:0];
    if (fits) begin
      rem_next = diff[WIDTH-1:0];
    end
    quo_next  = {quo[WIDTH-2:0], fits};
    quo_final = sign_q ? -quo_next : quo_next;
    rem_final = sign_r ? -rem_next : rem_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      div_zero <= 1'b0;
      sel_rem  <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_rem <= op[1];
            sign_q  <= a_neg ^ b_neg;
            sign_r  <= a_neg;
            if (B == '0) begin
              // Divide by zero: quotient all ones, remainder is the raw dividend.
              Result   <= op[1] ? A : '1;
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= FINISH;
            end else begin
              divisor <= b_abs;
              quo     <= a_abs;
              rem     <= '0;
              count   <= CW'(WIDTH);
              busy    <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            // Final step: register the signed-corrected result so it is valid with done.
            Result   <= sel_rem ? rem_final : quo_final;
            div_zero <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results, checked when done pulses.
module tb_div_unit;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [1:0]   op_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_zero;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (a_in),
    .B        (b_in),
    .op       (op_in),
    .busy     (busy),
    .done     (done),
    .Result   (result),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int           lat;
    int           busy_n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  // Independent reference: RV64M semantics including divide-by-zero and signed overflow.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa, sb_v;
    sa   = a;
    sb_v = b;
    e.dz = (b == '0);
    if (e.dz) e.res = o[1] ? a : '1;
    else if (!o[0] && a == MIN_S && b == '1) e.res = o[1] ? '0 : MIN_S;
    else begin
      case (o)
        2'b00:   e.res = sa / sb_v;
        2'b01:   e.res = a / b;
        2'b10:   e.res = sa % sb_v;
        default: e.res = a % b;
      endcase
    end
    e.lat    = e.dz ? 1 : W + 1;
    e.busy_n = e.dz ? 0 : W;
    return e;
  endfunction

  // Drive one request, push its expectation, then wait (bounded) for done and compare.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res, input bit disturb);
    exp_t e, got_e;
    int   cyc, busy_cyc, extra_done;
    e     = model(o, a, b);
    e.res = exp_res;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; op_in = o;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cyc = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cyc++;
      if (disturb && cyc == 10) begin start = 1'b1; a_in = 64'd77; b_in = 64'd5; op_in = 2'b11; end
      if (disturb && cyc == 11) begin start = 1'b0; a_in = 64'd12345; b_in = 64'd9; end
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
      void'(sb.pop_front());
      return;
    end
    got_e = sb.pop_front();
    check({tag, "_result"}, result, got_e.res);
    check({tag, "_div_zero"}, W'(div_zero), W'(got_e.dz));
    check({tag, "_latency"}, W'(cyc), W'(got_e.lat));
    check({tag, "_busy_cycles"}, W'(busy_cyc), W'(got_e.busy_n));
    check({tag, "_busy_at_done"}, W'(busy), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, W'(done), 0);
    check({tag, "_result_held"}, result, got_e.res);
    if (disturb) begin
      extra_done = 0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      check({tag, "_no_extra_done"}, W'(extra_done), 0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    exp_t         re;
    int           dones;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_in = 2'b00;
    #1;
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_result", result, 0);
    check("reset_div_zero", W'(div_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("divu_100_7",  2'b01, 64'd100, 64'd7, 64'd14, 1'b0);
    do_op("remu_100_7",  2'b11, 64'd100, 64'd7, 64'd2, 1'b0);
    do_op("div_m7_2",    2'b00, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    do_op("rem_m7_2",    2'b10, -64'sd7, 64'd2, '1, 1'b0);
    do_op("rem_7_m2",    2'b10, 64'd7, -64'sd2, 64'd1, 1'b0);
    do_op("divu_5_0",    2'b01, 64'd5, 64'd0, '1, 1'b0);
    do_op("div_5_0",     2'b00, 64'd5, 64'd0, '1, 1'b0);
    do_op("rem_m5_0",    2'b10, -64'sd5, 64'd0, -64'sd5, 1'b0);
    do_op("div_ovf",     2'b00, MIN_S, '1, MIN_S, 1'b0);
    do_op("rem_ovf",     2'b10, MIN_S, '1, 64'd0, 1'b0);
    do_op("divu_ignore", 2'b01, 64'd1000, 64'd3, 64'd333, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = (i < 3) ? {32'd0, $urandom} : {$urandom_range(3, 0), $urandom};
      ro = 2'($urandom_range(3, 0));
      re = model(ro, ra, rb);
      do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, re.res, 1'b0);
    end

    // Abort a running divide with reset: outputs clear at once and no done follows.
    @(negedge clk);
    start = 1'b1; a_in = 64'd1000; b_in = 64'd7; op_in = 2'b01;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 30; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), 0);
    check("abort_done", W'(done), 0);
    check("abort_result", result, 0);
    check("abort_div_zero", W'(div_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", W'(dones), 0);
    do_op("divu_9_3", 2'b01, 64'd9, 64'd3, 64'd3, 1'b0);

    check("scoreboard_empty", W'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 64-bit integer divider for the RV64M DIV/DIVU/REM/REMU instructions. It accepts operands on a start pulse and produces one quotient bit per cycle with a restoring shift-subtract algorithm. It returns the selected quotient or remainder with a one-cycle done pulse. It sits beside the combinational ALU in the execute stage, and the core stalls on `busy` while it runs.

## Interface
- `WIDTH`, default 64: operand and result width; must be ≥ 2.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `A`  in  WIDTH: dividend.
- `B`  in  WIDTH: divisor.
- `op`  in  2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; `Result` is valid from this cycle.
- `Result`  out  WIDTH: quotient or remainder; held until the next accepted start.
- `div_zero`  out  1: set with `done` when B == 0; held with `Result`.

## Operation
- States are IDLE, RUN and FINISH. Reset enters IDLE.
- **IDLE with `start`:**
  - Latch `op`.
  - Signed ops (`op[0]` = 0):
    - Record sign_q = A[W-1] ^ B[W-1] and sign_r = A[W-1].
    - Latch |A| and |B| as unsigned. |−2^(W-1)| = 2^(W-1) unsigned.
  - Unsigned ops: latch A and B unchanged; sign_q = sign_r = 0.
  - If B == 0, go to FINISH directly with the zero flag set. Otherwise clear rem, load quotient shift register Q = |A|, set count = W and go to RUN.
- **RUN, each cycle:**
  - Compute t = {rem[W-1:0], Q[W-1]} (W+1 bits).
  - If t ≥ divisor: rem = t − divisor, shift 1 into Q. Otherwise rem = t, shift 0 into Q.
  - Decrement count. When count reaches 1 on this cycle, go to FINISH.
- **FINISH, one cycle:**
  - Drive `Result` and `div_zero`, and pulse `done`. Return to IDLE.
  - Normal case, quotient: sign_q ? −Q : Q.
  - Normal case, remainder: sign_r ? −rem : rem.
  - Divide by zero: quotient = all ones for both DIV and DIVU; remainder = original A, unmodified; `div_zero` = 1.
  - Signed overflow (−2^(W-1) / −1) needs no special path: quotient = −2^(W-1), remainder = 0.
- `start` in RUN or FINISH is ignored; no queueing.
- Operand changes after the start cycle have no effect.
- Reset asserted mid-operation aborts immediately.
  - State goes to IDLE.
  - `busy`, `done`, `div_zero` = 0 and `Result` = 0.
  - No `done` is produced for the aborted operation.

## Timing
- Reset values: `busy` 0, `done` 0, `Result` 0, `div_zero` 0.
- Normal latency: start sampled at edge 0. `busy` is high in cycles 1..W and FINISH is cycle W+1. `done` is registered and high for exactly cycle W+1 (65 cycles for W = 64).
- Divide by zero: `done` in cycle 1 and `busy` never asserts.
- `Result` and `div_zero` are registered and update only on the FINISH cycle.
- Back-to-back: `start` may be asserted in the cycle after `done` (state is IDLE again). `start` coincident with `done` is ignored.
- All outputs come from flops. The only combinational logic is the (W+1)-bit compare/subtract path and the final negations.

## Test plan
- DIVU A=100, B=7 → `done` at cycle 65, `Result`=14. REMU with the same operands → `Result`=2. `busy` high cycles 1–64.
- DIV A=−7, B=2 → `Result`=−3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands → −1 (all ones). REM A=7, B=−2 → 1.
- DIVU A=5, B=0 → `done` at cycle 1, `Result`=0xFFFF_FFFF_FFFF_FFFF, `div_zero`=1, `busy` never high. REM A=−5, B=0 → `Result`=−5.
- DIV A=0x8000_0000_0000_0000, B=0xFFFF_FFFF_FFFF_FFFF → `Result`=0x8000_0000_0000_0000. REM with the same operands → 0. `div_zero`=0.
- Start DIVU 1000/3, pulse `start` again with other operands at cycle 10, and change A/B mid-run → `Result`=333 at cycle 65 and only one `done`.
- Start DIVU, assert `rst_n`=0 at cycle 30 for 2 cycles → `busy`, `done`, `Result` = 0 immediately and no `done` afterwards. A fresh DIVU 9/3 then gives 3 at cycle 65 of its own run.
